pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline. It decides each cycle whether the PC and the IF/ID register load, hold or flush, and whether a bubble goes into ID/EX. It handles load-use stalls, taken-branch flushes, data-memory freezes and the post-reset flush of the un-reset IF/ID register. It also keeps saturating stall and flush counters for performance inspection.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipeline_ctrl_if.sv | 34 +++
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_ctrl.sv | 90 +++++++++
 tb/tb_pipeline_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT        = 2'd0,
        ST_RUN         = 2'd1,
        ST_FREEZE      = 2'd2,
        ST_FREEZE_PEND = 2'd3
    } state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    // $zero is never a real producer, so a load into it cannot cause a hazard
    function automatic logic load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/sequencing signals between the datapath and pipeline_ctrl
interface pipeline_ctrl_if #(parameter int CNT_W = 16);

    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_Rt;
    logic             Branch_Taken;
    logic             DMem_Busy;
    logic             Cnt_Clr;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             Pipe_Hold;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt,
               Branch_Taken, DMem_Busy, Cnt_Clr,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold,
               Stall_Count, Flush_Count
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt,
               Branch_Taken, DMem_Busy, Cnt_Clr,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold,
               Stall_Count, Flush_Count
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Clr,
    input  logic         Inc,
    output logic [W-1:0] Q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr) begin
            cnt_d = '0;
        end else if (Inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - load/hold/flush sequencing for the five-stage pipeline
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            Clk,
    input  logic            Rst,
    pipeline_ctrl_if.slave  bus
);

    state_e state_q;
    state_e state_d;

    logic lu;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_hold;
    logic stall_inc;
    logic flush_inc;

    assign lu = load_use(bus.EX_MemRead, bus.EX_Rt, bus.ID_Rs, bus.ID_Rt, bus.ID_UsesRt);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = ST_RUN;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (state_q == ST_INIT) begin
            // IF/ID has no reset, so it is cleared while the reset-vector fetch is issued
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bus.DMem_Busy) begin
            pipe_hold = 1'b1;
            stall_inc = 1'b1;
            state_d   = (bus.Branch_Taken || state_q == ST_FREEZE_PEND) ? ST_FREEZE_PEND
                                                                       : ST_FREEZE;
        end else if (bus.Branch_Taken || state_q == ST_FREEZE_PEND) begin
            // ID holds a wrong-path instruction, so any load-use on it is irrelevant
            pc_write    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (lu) begin
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    assign bus.PC_Write    = pc_write;
    assign bus.IF_ID_Write = if_id_write;
    assign bus.IF_ID_Flush = if_id_flush;
    assign bus.ID_EX_Flush = id_ex_flush;
    assign bus.Pipe_Hold   = pipe_hold;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .Clr (bus.Cnt_Clr),
        .Inc (stall_inc),
        .Q   (bus.Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .Clr (bus.Cnt_Clr),
        .Inc (flush_inc),
        .Q   (bus.Flush_Count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic [4:0] in_rs, in_rt, in_ex_rt;
    logic       in_uses, in_mr, in_bt, in_busy, in_clr;

    pipeline_ctrl_if #(.CNT_W(16)) bus  ();
    pipeline_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus.ID_Rs  = in_rs;      assign bus2.ID_Rs  = in_rs;
    assign bus.ID_Rt  = in_rt;      assign bus2.ID_Rt  = in_rt;
    assign bus.ID_UsesRt = in_uses; assign bus2.ID_UsesRt = in_uses;
    assign bus.EX_MemRead = in_mr;  assign bus2.EX_MemRead = in_mr;
    assign bus.EX_Rt  = in_ex_rt;   assign bus2.EX_Rt  = in_ex_rt;
    assign bus.Branch_Taken = in_bt; assign bus2.Branch_Taken = in_bt;
    assign bus.DMem_Busy = in_busy; assign bus2.DMem_Busy = in_busy;
    assign bus.Cnt_Clr = in_clr;    assign bus2.Cnt_Clr = in_clr;

    pipeline_ctrl #(.CNT_W(16)) dut  (.Clk(Clk), .Rst(Rst), .bus(bus.slave));
    pipeline_ctrl #(.CNT_W(2))  dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2.slave));

    // output vector order: PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Hold
    logic [4:0] act1, act2;
    assign act1 = {bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.Pipe_Hold};
    assign act2 = {bus2.PC_Write, bus2.IF_ID_Write, bus2.IF_ID_Flush, bus2.ID_EX_Flush, bus2.Pipe_Hold};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: pipeline is either just out of reset, or running with
    // an optional remembered branch redirect.
    bit m_init = 1'b1;
    bit m_pend = 1'b0;
    int m_s16 = 0, m_f16 = 0, m_s2 = 0, m_f2 = 0;

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic bit lu_now();
        return in_mr && (in_ex_rt != 0) &&
               ((in_ex_rt == in_rs) || (in_uses && (in_ex_rt == in_rt)));
    endfunction

    function automatic logic [4:0] model_out();
        if (m_init)             return 5'b00110;
        if (in_busy)            return 5'b00001;
        if (in_bt || m_pend)    return 5'b10110;
        if (lu_now())           return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic model_reset();
        m_init = 1'b1; m_pend = 1'b0;
        m_s16 = 0; m_f16 = 0; m_s2 = 0; m_f2 = 0;
    endtask

    task automatic model_clock();
        bit st = 1'b0;
        bit fl = 1'b0;
        if (m_init) begin
            m_init = 1'b0;
        end else if (in_busy) begin
            st = 1'b1;
            m_pend = m_pend || in_bt;
        end else if (in_bt || m_pend) begin
            fl = 1'b1;
            m_pend = 1'b0;
        end else if (lu_now()) begin
            st = 1'b1;
        end
        if (in_clr) begin
            m_s16 = 0; m_f16 = 0; m_s2 = 0; m_f2 = 0;
        end else begin
            if (st) begin m_s16 = sat_inc(m_s16, 65535); m_s2 = sat_inc(m_s2, 3); end
            if (fl) begin m_f16 = sat_inc(m_f16, 65535); m_f2 = sat_inc(m_f2, 3); end
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                          input logic uses, input logic mr, input logic bt,
                          input logic busy, input logic clr);
        in_rs = rs; in_rt = rt; in_ex_rt = ex_rt;
        in_uses = uses; in_mr = mr; in_bt = bt; in_busy = busy; in_clr = clr;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // called just after a negedge with inputs applied; leaves us at the next negedge
    task automatic step(input string tag);
        #1;
        chk({tag, " outputs"}, act1, model_out());
        chk({tag, " outputs cnt2"}, act2, model_out());
        @(posedge Clk);
        model_clock();
        @(negedge Clk);
        chk({tag, " stall16"}, bus.Stall_Count, m_s16);
        chk({tag, " flush16"}, bus.Flush_Count, m_f16);
        chk({tag, " stall2"}, bus2.Stall_Count, m_s2);
        chk({tag, " flush2"}, bus2.Flush_Count, m_f2);
    endtask

    typedef struct {
        logic [4:0] rs, rt, ex_rt;
        logic       uses, mr, bt, busy, clr;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[2] = '{5'd1, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[3] = '{5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[4] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10110};
        vecs[5] = '{5'd3, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[6] = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b00010};
        vecs[7] = '{5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00001};
        vecs[8] = '{5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};

        idle();
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("reset outputs", act1, 5'b00110);
        chk("reset stall", bus.Stall_Count, 0);
        chk("reset flush", bus.Flush_Count, 0);
        Rst = 1'b0;
        step("init cycle");
        chk("first fetch", act1, 5'b11000);
        step("first fetch");

        foreach (vecs[i]) begin
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].ex_rt, vecs[i].uses,
                   vecs[i].mr, vecs[i].bt, vecs[i].busy, vecs[i].clr);
            #1;
            chk($sformatf("vec%0d table", i), act1, vecs[i].exp);
            step($sformatf("vec%0d", i));
        end

        // freeze of 4 cycles with a branch arriving in the 2nd
        idle(); in_clr = 1'b1; step("freeze clr");
        for (int c = 1; c <= 4; c++) begin
            idle(); in_busy = 1'b1; in_bt = (c == 2);
            #1;
            chk($sformatf("freeze c%0d hold", c), act1, 5'b00001);
            step($sformatf("freeze c%0d", c));
        end
        idle();
        #1;
        chk("freeze c5 flush", act1, 5'b10110);
        step("freeze c5");
        chk("freeze stall total", bus.Stall_Count, 4);
        chk("freeze flush total", bus.Flush_Count, 1);
        idle(); #1; chk("after freeze normal", act1, 5'b11000); step("after freeze");

        // saturation of the 2-bit counter
        idle(); in_clr = 1'b1; step("sat clr");
        for (int c = 0; c < 5; c++) begin
            set_in(5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step($sformatf("sat lu%0d", c));
        end
        chk("sat stall2 max", bus2.Stall_Count, 3);
        chk("sat stall16", bus.Stall_Count, 5);
        set_in(5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("clr with stall");
        chk("clr wins stall2", bus2.Stall_Count, 0);
        chk("clr wins stall16", bus.Stall_Count, 0);

        // reset during a freeze with a pending redirect
        idle(); in_busy = 1'b1; in_bt = 1'b1; step("pend before rst");
        in_bt = 1'b0;
        Rst = 1'b1;
        #1;
        model_reset();
        chk("midrst outputs", act1, 5'b00110);
        chk("midrst stall", bus.Stall_Count, 0);
        chk("midrst flush", bus.Flush_Count, 0);
        @(negedge Clk);
        Rst = 1'b0;
        idle();
        step("midrst init");
        #1;
        chk("midrst pending dropped", act1, 5'b11000);
        step("midrst run");

        for (int n = 0; n < 400; n++) begin
            in_rs    = 5'($urandom_range(0, 3));
            in_rt    = 5'($urandom_range(0, 3));
            in_ex_rt = 5'($urandom_range(0, 3));
            in_uses  = 1'($urandom_range(0, 1));
            in_mr    = 1'($urandom_range(0, 1));
            in_bt    = ($urandom_range(0, 7) == 0);
            in_busy  = ($urandom_range(0, 4) == 0);
            in_clr   = ($urandom_range(0, 40) == 0);
            step($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
